multdiv_issue_ctrl: RTL and testbench

- Two-requester front end for the shared `multdiv` unit.
- Arbitrates round-robin between two issue ports and registers the winning operands and opcode.
- Sends a single-cycle `ctrl_MULT` or `ctrl_DIV` start pulse and holds the operands stable until `data_resultRDY`.
- Returns result, exception and requester ID through a valid/ready output port; a watchdog converts a lost ready into an exception.
- Sits between the execute stage and `multdiv`; the only block allowed to drive `multdiv` control inputs.

---
 rtl/multdiv_issue_ctrl_if.sv | 51 +++++
 rtl/multdiv_issue_ctrl.sv | 129 ++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_issue_ctrl_if.sv
// Bus bundle between the execute-stage requesters, the shared multdiv unit and
// the result consumer; slave is the issue controller's view, master the environment's.
interface multdiv_issue_ctrl_if;
  logic        req0_valid;
  logic        req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic        req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ready;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_exception;
  logic        out_id;
  logic        out_timeout;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  md_result, md_exception, md_resultRDY,
    output out_valid,
    input  out_ready,
    output out_result, out_exception, out_id, out_timeout
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output md_result, md_exception, md_resultRDY,
    input  out_valid,
    output out_ready,
    input  out_result, out_exception, out_id, out_timeout
  );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// Round-robin issue front end for the shared multdiv unit: grants one of two
// requesters, pulses the start control, waits for ready (with watchdog) and holds the result.
module multdiv_issue_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic               clk_i,
  input  logic               rst_i,
  multdiv_issue_ctrl_if.slave bus_if,
  output logic               busy_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             id_q, id_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      result_q, result_d;
  logic             exc_q, exc_d;
  logic             timeout_q, timeout_d;
  logic             gnt0, gnt1;

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    gnt0 = bus_if.req0_valid & (~bus_if.req1_valid | last_grant_q);
    gnt1 = bus_if.req1_valid & (~bus_if.req0_valid | ~last_grant_q);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    exc_d        = exc_q;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        if (gnt0 | gnt1) begin
          id_d         = gnt1;
          op_d         = gnt1 ? bus_if.req1_op : bus_if.req0_op;
          a_d          = gnt1 ? bus_if.req1_a  : bus_if.req0_a;
          b_d          = gnt1 ? bus_if.req1_b  : bus_if.req0_b;
          last_grant_d = gnt1;
          state_d      = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Ready is only honoured here, so a stale ready after reset is harmless.
        if (bus_if.md_resultRDY) begin
          result_d  = bus_if.md_result;
          exc_d     = bus_if.md_exception;
          timeout_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == CNT_LAST) begin
          result_d  = '0;
          exc_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus_if.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      op_q         <= 1'b0;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      exc_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      exc_q        <= exc_d;
      timeout_q    <= timeout_d;
    end
  end

  // Ready is gated by reset so a requester held valid through reset is not acknowledged.
  assign bus_if.req0_ready    = (state_q == IDLE) & ~rst_i & gnt0;
  assign bus_if.req1_ready    = (state_q == IDLE) & ~rst_i & gnt1;
  assign bus_if.md_operandA   = a_q;
  assign bus_if.md_operandB   = b_q;
  assign bus_if.md_ctrl_MULT  = (state_q == START) & ~op_q;
  assign bus_if.md_ctrl_DIV   = (state_q == START) & op_q;
  assign bus_if.out_valid     = (state_q == DONE);
  assign bus_if.out_result    = result_q;
  assign bus_if.out_exception = exc_q;
  assign bus_if.out_id        = id_q;
  assign bus_if.out_timeout   = timeout_q;
  assign busy_o               = (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl with a small behavioural multdiv model
// that answers start pulses after a programmable delay.
`timescale 1ns/1ps
module tb_multdiv_issue_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  multdiv_issue_ctrl_if bus_if ();

  multdiv_issue_ctrl #(
    .TIMEOUT(64),
    .CNT_W  (7)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_if(bus_if),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int          mdDelay    = 5;
  bit          mdNever    = 1'b0;
  bit          mdPending  = 1'b0;
  int          mdCount    = 0;
  logic [31:0] mdRes      = '0;
  logic        mdExc      = 1'b0;
  logic        modelRdy   = 1'b0;
  logic        strayRdy   = 1'b0;
  int          multPulses = 0;
  int          divPulses  = 0;
  int          bothPulses = 0;
  int          rdyPulses  = 0;

  assign bus_if.md_resultRDY = modelRdy | strayRdy;
  assign bus_if.md_result    = mdRes;
  assign bus_if.md_exception = mdExc;

  // multdiv stand-in: runs on the falling edge, ignores reset like a real slow unit would.
  always @(negedge clk) begin
    modelRdy = 1'b0;
    if (mdPending) begin
      if (mdCount <= 1) begin
        modelRdy  = 1'b1;
        mdPending = 1'b0;
        rdyPulses = rdyPulses + 1;
      end else begin
        mdCount = mdCount - 1;
      end
    end
    if (bus_if.md_ctrl_MULT || bus_if.md_ctrl_DIV) begin
      if (bus_if.md_ctrl_MULT && bus_if.md_ctrl_DIV) bothPulses = bothPulses + 1;
      if (bus_if.md_ctrl_MULT) multPulses = multPulses + 1;
      if (bus_if.md_ctrl_DIV) divPulses = divPulses + 1;
      mdPending = !mdNever;
      mdCount   = mdDelay;
      if (bus_if.md_ctrl_DIV) begin
        if (bus_if.md_operandB == 32'd0) begin
          mdRes = '0;
          mdExc = 1'b1;
        end else begin
          mdRes = bus_if.md_operandA / bus_if.md_operandB;
          mdExc = 1'b0;
        end
      end else begin
        mdRes = bus_if.md_operandA * bus_if.md_operandB;
        mdExc = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!bus_if.out_valid && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic clear_inputs();
    bus_if.req0_valid = 1'b0;
    bus_if.req0_op    = 1'b0;
    bus_if.req0_a     = '0;
    bus_if.req0_b     = '0;
    bus_if.req1_valid = 1'b0;
    bus_if.req1_op    = 1'b0;
    bus_if.req1_a     = '0;
    bus_if.req1_b     = '0;
    bus_if.out_ready  = 1'b0;
    strayRdy          = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [104:0] obs;
    clear_inputs();
    rst = 1'b1;
    step();
    obs = {bus_if.md_ctrl_MULT, bus_if.md_ctrl_DIV, bus_if.md_operandA, bus_if.md_operandB,
           bus_if.out_valid, bus_if.out_result, bus_if.out_exception, bus_if.out_id,
           bus_if.out_timeout, busy, bus_if.req0_ready, bus_if.req1_ready};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h want 0", obs);
    end
    bus_if.req0_valid = 1'b1;
    bus_if.req1_valid = 1'b1;
    #1;
    checks++;
    if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_ready got %b want 00", {bus_if.req0_ready, bus_if.req1_ready});
    end
    clear_inputs();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single_mult();
    int m0, d0, b0, n;
    m0 = multPulses; d0 = divPulses; b0 = bothPulses;
    mdDelay = 20;
    bus_if.req0_valid = 1'b1; bus_if.req0_op = 1'b0;
    bus_if.req0_a = 32'd7; bus_if.req0_b = 32'd6;
    #1;
    checks++;
    if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL mult_grant got %b want 10", {bus_if.req0_ready, bus_if.req1_ready});
    end
    step();
    bus_if.req0_valid = 1'b0;
    checks++;
    if ({bus_if.md_ctrl_MULT, bus_if.md_ctrl_DIV, bus_if.md_operandA, bus_if.md_operandB}
        !== {1'b1, 1'b0, 32'd7, 32'd6}) begin
      errors++;
      $display("[TB] FAIL mult_start got %b%b %0d %0d want 10 7 6", bus_if.md_ctrl_MULT,
               bus_if.md_ctrl_DIV, bus_if.md_operandA, bus_if.md_operandB);
    end
    wait_valid(200, n);
    checks++;
    if (n !== 21) begin
      errors++;
      $display("[TB] FAIL mult_latency got %0d want 21", n);
    end
    checks++;
    if ({bus_if.out_result, bus_if.out_exception, bus_if.out_id, bus_if.out_timeout}
        !== {32'd42, 3'b000}) begin
      errors++;
      $display("[TB] FAIL mult_result got %0d %b%b%b want 42 000", bus_if.out_result,
               bus_if.out_exception, bus_if.out_id, bus_if.out_timeout);
    end
    checks++;
    if ((multPulses - m0) != 1 || (divPulses - d0) != 0 || (bothPulses - b0) != 0) begin
      errors++;
      $display("[TB] FAIL mult_pulses got mult=%0d div=%0d both=%0d want 1 0 0",
               multPulses - m0, divPulses - d0, bothPulses - b0);
    end
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
    checks++;
    if ({bus_if.out_valid, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL mult_handshake got %b want 00", {bus_if.out_valid, busy});
    end
  endtask

  task automatic test_contention();
    int n;
    logic [1:0] expGnt;
    clear_inputs();
    mdDelay = 3;
    bus_if.req0_valid = 1'b1; bus_if.req0_op = 1'b0; bus_if.req0_a = 32'd2; bus_if.req0_b = 32'd3;
    bus_if.req1_valid = 1'b1; bus_if.req1_op = 1'b0; bus_if.req1_a = 32'd4; bus_if.req1_b = 32'd5;
    bus_if.out_ready  = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      expGnt = (k == 1) ? 2'b01 : 2'b10;
      n = 0;
      while (!(bus_if.req0_ready || bus_if.req1_ready) && n < 50) begin
        step();
        n++;
      end
      checks++;
      if ({bus_if.req0_ready, bus_if.req1_ready} !== expGnt) begin
        errors++;
        $display("[TB] FAIL contention_grant%0d got %b want %b", k,
                 {bus_if.req0_ready, bus_if.req1_ready}, expGnt);
      end
      step();
      checks++;
      if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL contention_pulse%0d got %b want 00", k,
                 {bus_if.req0_ready, bus_if.req1_ready});
      end
      wait_valid(50, n);
      checks++;
      if ({bus_if.out_valid, bus_if.out_id} !== {1'b1, expGnt[0]}) begin
        errors++;
        $display("[TB] FAIL contention_id%0d got valid=%b id=%b want 1 %b", k,
                 bus_if.out_valid, bus_if.out_id, expGnt[0]);
      end
      step();
    end
    clear_inputs();
    step();
  endtask

  task automatic test_div_zero();
    int m0, d0, n;
    m0 = multPulses; d0 = divPulses;
    mdDelay = 5;
    bus_if.req1_valid = 1'b1; bus_if.req1_op = 1'b1;
    bus_if.req1_a = 32'd100; bus_if.req1_b = 32'd0;
    #1;
    checks++;
    if ({bus_if.req0_ready, bus_if.req1_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL div_grant got %b want 01", {bus_if.req0_ready, bus_if.req1_ready});
    end
    step();
    bus_if.req1_valid = 1'b0;
    wait_valid(50, n);
    checks++;
    if ({bus_if.out_valid, bus_if.out_result, bus_if.out_exception, bus_if.out_timeout, bus_if.out_id}
        !== {1'b1, 32'd0, 3'b101}) begin
      errors++;
      $display("[TB] FAIL div_zero got valid=%b res=%0d exc=%b to=%b id=%b want 1 0 1 0 1",
               bus_if.out_valid, bus_if.out_result, bus_if.out_exception,
               bus_if.out_timeout, bus_if.out_id);
    end
    checks++;
    if ((divPulses - d0) != 1 || (multPulses - m0) != 0) begin
      errors++;
      $display("[TB] FAIL div_pulses got div=%0d mult=%0d want 1 0", divPulses - d0, multPulses - m0);
    end
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_watchdog();
    int n;
    mdNever = 1'b1;
    bus_if.req0_valid = 1'b1; bus_if.req0_op = 1'b0;
    bus_if.req0_a = 32'd9; bus_if.req0_b = 32'd9;
    step();
    bus_if.req0_valid = 1'b0;
    wait_valid(200, n);
    checks++;
    if (n !== 65) begin
      errors++;
      $display("[TB] FAIL watchdog_latency got %0d want 65", n);
    end
    checks++;
    if ({bus_if.out_result, bus_if.out_exception, bus_if.out_timeout} !== {32'd0, 2'b11}) begin
      errors++;
      $display("[TB] FAIL watchdog_result got res=%0d exc=%b to=%b want 0 1 1",
               bus_if.out_result, bus_if.out_exception, bus_if.out_timeout);
    end
    mdNever = 1'b0;
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    mdDelay = 2;
    bus_if.req0_valid = 1'b1; bus_if.req0_op = 1'b0;
    bus_if.req0_a = 32'd3; bus_if.req0_b = 32'd5;
    step();
    bus_if.req0_valid = 1'b0;
    wait_valid(50, n);
    for (int k = 0; k < 10; k++) begin
      strayRdy          = k[0];
      bus_if.req0_valid = ~k[0];
      bus_if.req0_a     = 32'(k + 100);
      #1;
      checks++;
      if ({bus_if.out_valid, bus_if.out_result, bus_if.out_exception, bus_if.out_id,
           bus_if.out_timeout, bus_if.req0_ready, bus_if.md_ctrl_MULT, bus_if.md_ctrl_DIV}
          !== {1'b1, 32'd15, 6'b000000}) begin
        errors++;
        $display("[TB] FAIL hold%0d got valid=%b res=%0d exc=%b id=%b to=%b rdy=%b ctl=%b%b want 1 15 0 0 0 0 00",
                 k, bus_if.out_valid, bus_if.out_result, bus_if.out_exception, bus_if.out_id,
                 bus_if.out_timeout, bus_if.req0_ready, bus_if.md_ctrl_MULT, bus_if.md_ctrl_DIV);
      end
      step();
    end
    strayRdy = 1'b0;
    bus_if.req0_valid = 1'b1; bus_if.req0_a = 32'd2; bus_if.req0_b = 32'd9;
    bus_if.out_ready  = 1'b1;
    #1;
    checks++;
    if (bus_if.req0_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_grant_in_done got %b want 0", bus_if.req0_ready);
    end
    step();
    bus_if.out_ready = 1'b0;
    checks++;
    if ({bus_if.out_valid, bus_if.req0_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL grant_after_done got valid=%b rdy=%b want 0 1",
               bus_if.out_valid, bus_if.req0_ready);
    end
    step();
    bus_if.req0_valid = 1'b0;
    checks++;
    if ({bus_if.md_ctrl_MULT, bus_if.md_operandA, bus_if.md_operandB} !== {1'b1, 32'd2, 32'd9}) begin
      errors++;
      $display("[TB] FAIL next_start got %b %0d %0d want 1 2 9", bus_if.md_ctrl_MULT,
               bus_if.md_operandA, bus_if.md_operandB);
    end
    wait_valid(50, n);
    checks++;
    if ({bus_if.out_valid, bus_if.out_result} !== {1'b1, 32'd18}) begin
      errors++;
      $display("[TB] FAIL next_result got valid=%b res=%0d want 1 18", bus_if.out_valid, bus_if.out_result);
    end
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int n, bad, r0;
    logic [104:0] obs;
    mdDelay = 20;
    r0 = rdyPulses;
    bus_if.req1_valid = 1'b1; bus_if.req1_op = 1'b0;
    bus_if.req1_a = 32'd11; bus_if.req1_b = 32'd3;
    step();
    bus_if.req1_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    obs = {bus_if.md_ctrl_MULT, bus_if.md_ctrl_DIV, bus_if.md_operandA, bus_if.md_operandB,
           bus_if.out_valid, bus_if.out_result, bus_if.out_exception, bus_if.out_id,
           bus_if.out_timeout, busy, bus_if.req0_ready, bus_if.req1_ready};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs got %h want 0", obs);
    end
    step();
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (bus_if.out_valid || busy) bad++;
    end
    checks++;
    if (bad !== 0 || (rdyPulses - r0) < 1) begin
      errors++;
      $display("[TB] FAIL stale_ready got busy_cycles=%0d rdy_pulses=%0d want 0 >=1", bad, rdyPulses - r0);
    end
    obs = {bus_if.md_ctrl_MULT, bus_if.md_ctrl_DIV, bus_if.md_operandA, bus_if.md_operandB,
           bus_if.out_valid, bus_if.out_result, bus_if.out_exception, bus_if.out_id,
           bus_if.out_timeout, busy, bus_if.req0_ready, bus_if.req1_ready};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got %h want 0", obs);
    end
    mdDelay = 3;
    bus_if.req0_valid = 1'b1; bus_if.req0_op = 1'b0;
    bus_if.req0_a = 32'd4; bus_if.req0_b = 32'd5;
    step();
    bus_if.req0_valid = 1'b0;
    wait_valid(50, n);
    checks++;
    if ({bus_if.out_valid, bus_if.out_result, bus_if.out_exception, bus_if.out_id, bus_if.out_timeout}
        !== {1'b1, 32'd20, 3'b000}) begin
      errors++;
      $display("[TB] FAIL after_reset_op got valid=%b res=%0d exc=%b id=%b to=%b want 1 20 0 0 0",
               bus_if.out_valid, bus_if.out_result, bus_if.out_exception, bus_if.out_id,
               bus_if.out_timeout);
    end
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_mult();
    test_contention();
    test_div_zero();
    test_watchdog();
    test_backpressure();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
